period_averager: RTL
====================

# period_averager

Downstream consumer of the edge-to-edge period counter. Takes each `new_data` strobe with its 8-bit period value and range-checks it against fixed limits. It keeps a running average over the last 2^DEPTH_LOG2 in-range periods and presents the result on a valid/ready output with a single-entry hold register. It also reports lock status, meaning the window is full of consecutive in-range samples.

## Interface
- `DEPTH_LOG2`, default 2: window size N = 2^DEPTH_LOG2 samples; legal range 1..4.
- `LO_LIMIT`, default 8'd4: smallest accepted period, inclusive.
- `HI_LIMIT`, default 8'd250: largest accepted period, inclusive.

Ports:
- `clk` in, 1: clock, rising edge.
- `reset` in, 1: reset, asynchronous, active-low.
- `new_data` in, 1: single-cycle strobe; `din` is valid this cycle.
- `din` in, 8: measured period in clk cycles.
- `avg_ready` in, 1: consumer accepts `avg` this cycle.
- `avg_valid` out, 1: `avg` holds an unconsumed result.
- `avg` out, 8: windowed average period.
- `locked` out, 1: window filled with N consecutive in-range samples.
- `out_of_range` out, 1: one-cycle pulse when a sample was rejected.
- `overflow` out, 1: one-cycle pulse when an unconsumed result was overwritten.

## Operation
- Storage: N×8 circular buffer `win`, write pointer `wr_ptr` (DEPTH_LOG2 bits, wraps N-1→0), fill counter, running `sum` of 8+DEPTH_LOG2 bits. No overflow is possible in `sum`.
- Sample accepted when `new_data`=1 and LO_LIMIT ≤ `din` ≤ HI_LIMIT. `new_data`=0 means no action, regardless of `din`.
- FSM states:
  - FILL, the reset state:
    - Accepted sample: `win[wr_ptr]`←`din`, `sum`←`sum`+`din`, `wr_ptr`++, count++.
    - On the N-th accepted sample: → RUN, `locked`←1, and a result is produced from the new `sum`.
    - No results are produced before that.
  - RUN:
    - Accepted sample: `sum`←`sum`+`din`−`win[wr_ptr]` (oldest entry), `win[wr_ptr]`←`din`, `wr_ptr`++.
    - Every accepted sample produces a result.
- Rejected sample, in any state:
  - `out_of_range` pulses.
  - FSM → FILL, `locked`←0, `sum`←0, count←0, `wr_ptr`←0.
  - `win` contents are not cleared; they are never read in FILL.
  - A pending `avg`/`avg_valid` is untouched.
- Result: `avg` = `sum_next` >> DEPTH_LOG2 (truncating; see Configuration), loaded into the output register.
- Output handshake:
  - Transfer occurs when `avg_valid`=1 and `avg_ready`=1.
  - After a transfer, `avg_valid`←0 unless a new result is loaded in the same cycle.
  - If a new result arrives while `avg_valid`=1 and `avg_ready`=0: `avg` is overwritten, `avg_valid` stays 1, and `overflow` pulses.
  - If a new result arrives in the same cycle as a transfer: the new result is loaded, `avg_valid` stays 1, no `overflow`.
  - `avg` is stable while `avg_valid`=1 and no new result arrives.

## Timing
- Reset (async assert):
  - `avg_valid`=0, `avg`=0, `locked`=0, `out_of_range`=0, `overflow`=0.
  - `sum`=0, count=0, `wr_ptr`=0, `win` all 0, FSM=FILL.
- Reset mid-operation discards the pending result and the window; no output pulse on release.
- Latency: strobe in cycle t → `avg`/`avg_valid` updated at the clock edge ending t, visible in cycle t+1.
  - `locked` rises and `out_of_range` pulses in the same cycle.
  - `overflow` pulses in the same cycle.
- Back-to-back strobes in consecutive cycles are supported at full rate.
- `locked` falls in cycle t+1 after a rejected strobe in cycle t.

## Configuration
- `PERIOD_AVG_ROUND_EN` defined:
  - `avg` = (`sum_next` + 2^(DEPTH_LOG2−1)) >> DEPTH_LOG2, i.e. round half up.
  - The addition uses one extra bit. The result never exceeds 255 for 8-bit inputs.
- Not defined: plain truncation, `avg` = `sum_next` >> DEPTH_LOG2.

## Test plan
- Fill and lock: four strobes, `din`=100, DEPTH_LOG2=2.
  - No `avg_valid` after strobes 1–3.
  - After strobe 4: `avg_valid`=1, `avg`=100, `locked`=1.
- Sliding window: continue from locked state with a strobe of `din`=104.
  - `sum`=404, `avg`=101.
  - Then `din`=108 → `sum`=412, `avg`=103.
- Rejection: while locked, strobe `din`=2.
  - `out_of_range` pulses for 1 cycle and `locked`=0.
  - Pending `avg` unchanged.
  - Three further in-range strobes give no result; the 4th gives `avg_valid`.
  - Repeat with `din`=251 and `din`=250; 250 must be accepted.
- Stall: hold `avg_ready`=0 and produce two results (101, 103).
  - `overflow` pulses once; `avg`=103, `avg_valid`=1.
  - Then raise `avg_ready` together with a new strobe: no `overflow`, `avg` updates, `avg_valid` stays 1.
- Rounding: fill with 10, 11, 11, 11 (`sum`=43).
  - Without the macro: `avg`=10.
  - With `PERIOD_AVG_ROUND_EN`: `avg`=11.
- Reset mid-run: assert `reset` asynchronously while `avg_valid`=1 and `locked`=1.
  - All outputs drop to 0 immediately.
  - After release, four strobes of 50 are needed before `avg`=50.

Source files
------------

// File: rtl/period_averager_if.sv
// Sample-in / average-out bundle for period_averager.
// The slave modport is the averager; the master modport is its environment.
interface period_averager_if;
    logic       new_data;
    logic [7:0] din;
    logic       avg_ready;
    logic       avg_valid;
    logic [7:0] avg;
    logic       locked;
    logic       out_of_range;
    logic       overflow;

    modport master (
        output new_data, din, avg_ready,
        input  avg_valid, avg, locked, out_of_range, overflow
    );

    modport slave (
        input  new_data, din, avg_ready,
        output avg_valid, avg, locked, out_of_range, overflow
    );
endinterface

// File: rtl/period_averager.sv
// Sliding-window average over the last 2**DEPTH_LOG2 in-range period samples, with valid/ready output.
// Optional feature macro PERIOD_AVG_ROUND_EN: round half up instead of truncating.
module period_averager #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [7:0]  LO_LIMIT   = 8'd4,
    parameter logic [7:0]  HI_LIMIT   = 8'd250
) (
    input logic              clk,
    input logic              reset,
    period_averager_if.slave bus
);
    localparam int unsigned N     = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = 8 + DEPTH_LOG2;

    typedef enum logic {FILL, RUN} state_e;

    state_e                 state_q;
    logic [7:0]             win_q [N];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  count_q;
    logic [SUM_W-1:0]       sum_q;
    logic [SUM_W-1:0]       sum_d;
    logic [7:0]             avg_q;
    logic [7:0]             avg_d;
    logic                   avg_valid_q;
    logic                   locked_q;
    logic                   oor_q;
    logic                   ovf_q;
    logic                   accept;
    logic                   reject;
    logic                   last_fill;
    logic                   produce;

    // In RUN the oldest entry sits at wr_ptr and is swapped out of the sum.
    always_comb begin
        accept    = bus.new_data && (bus.din >= LO_LIMIT) && (bus.din <= HI_LIMIT);
        reject    = bus.new_data && !accept;
        last_fill = &count_q;
        produce   = accept && ((state_q == RUN) || last_fill);
        if (state_q == RUN)
            sum_d = sum_q + SUM_W'(bus.din) - SUM_W'(win_q[wr_ptr_q]);
        else
            sum_d = sum_q + SUM_W'(bus.din);
    end

`ifdef PERIOD_AVG_ROUND_EN
    localparam int unsigned RND_W = SUM_W + 1;
    logic [RND_W-1:0] sum_rnd;

    always_comb begin
        sum_rnd = {1'b0, sum_d} + RND_W'(N / 2);
        avg_d   = 8'(sum_rnd >> DEPTH_LOG2);
    end
`else
    always_comb begin
        avg_d = 8'(sum_d >> DEPTH_LOG2);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            oor_q       <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
        end else begin
            oor_q <= reject;

            // A rejected sample restarts the fill; the stale window is never read in FILL.
            if (reject) begin
                state_q  <= FILL;
                locked_q <= 1'b0;
                sum_q    <= '0;
                count_q  <= '0;
                wr_ptr_q <= '0;
            end else if (accept) begin
                win_q[wr_ptr_q] <= bus.din;
                sum_q           <= sum_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                if (state_q == FILL) begin
                    count_q <= count_q + 1'b1;
                    if (last_fill) begin
                        state_q  <= RUN;
                        locked_q <= 1'b1;
                    end
                end
            end

            // A result landing on an unconsumed one replaces it and flags the loss.
            if (produce) begin
                avg_q       <= avg_d;
                avg_valid_q <= 1'b1;
                ovf_q       <= avg_valid_q && !bus.avg_ready;
            end else begin
                ovf_q <= 1'b0;
                if (avg_valid_q && bus.avg_ready) avg_valid_q <= 1'b0;
            end
        end
    end

    assign bus.avg          = avg_q;
    assign bus.avg_valid    = avg_valid_q;
    assign bus.locked       = locked_q;
    assign bus.out_of_range = oor_q;
    assign bus.overflow     = ovf_q;
endmodule
